// File: rtl/tausworthe_pkg.sv
// Shared constants for the taus88 uniform generator: seed scramble words,
// minimum-state OR masks and the per-component shift/mask triplets.
package tausworthe_pkg;

  typedef logic [31:0] word_t;

  localparam word_t SEED_C0 = 32'h1234_5678;
  localparam word_t SEED_C1 = 32'h8765_4321;
  localparam word_t SEED_C2 = 32'hDEAD_BEEF;

  // ORed into each seeded component so the taus88 lower bounds always hold
  localparam word_t MIN_OR0 = 32'h0000_0002;
  localparam word_t MIN_OR1 = 32'h0000_0008;
  localparam word_t MIN_OR2 = 32'h0000_0010;

  localparam int unsigned SH0_A = 13;
  localparam int unsigned SH0_B = 19;
  localparam int unsigned SH0_C = 12;
  localparam int unsigned SH1_A = 2;
  localparam int unsigned SH1_B = 25;
  localparam int unsigned SH1_C = 4;
  localparam int unsigned SH2_A = 3;
  localparam int unsigned SH2_B = 11;
  localparam int unsigned SH2_C = 17;

  localparam word_t MASK0 = 32'hFFFF_FFFE;
  localparam word_t MASK1 = 32'hFFFF_FFF8;
  localparam word_t MASK2 = 32'hFFFF_FFF0;

endpackage

// File: rtl/tausworthe_step.sv
// One Tausworthe component advance, purely combinational:
// nxt = ((st & MASK) << SC) ^ (((st << SA) ^ st) >> SB).
module tausworthe_step
  import tausworthe_pkg::*;
#(
  parameter int unsigned SA   = 13,
  parameter int unsigned SB   = 19,
  parameter int unsigned SC   = 12,
  parameter word_t       MASK = 32'hFFFF_FFFE
) (
  input  logic [31:0] st,
  output logic [31:0] nxt
);

  logic [31:0] fb;

  assign fb  = ((st << SA) ^ st) >> SB;
  assign nxt = ((st & MASK) << SC) ^ fb;

endmodule

// File: rtl/tausworthe.sv
// Combined three-component Tausworthe URNG (taus88): seeds from s on the first
// edge after reset release, then emits one registered 32-bit word per clock.
module tausworthe
  import tausworthe_pkg::*;
#(
  parameter word_t C0 = SEED_C0,
  parameter word_t C1 = SEED_C1,
  parameter word_t C2 = SEED_C2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s,
  output logic [31:0] y
);

  logic [31:0] st0, st1, st2;
  logic [31:0] nxt0, nxt1, nxt2;
  logic        seeded;

  tausworthe_step #(.SA(SH0_A), .SB(SH0_B), .SC(SH0_C), .MASK(MASK0)) u_step0 (
    .st  (st0),
    .nxt (nxt0)
  );

  tausworthe_step #(.SA(SH1_A), .SB(SH1_B), .SC(SH1_C), .MASK(MASK1)) u_step1 (
    .st  (st1),
    .nxt (nxt1)
  );

  tausworthe_step #(.SA(SH2_A), .SB(SH2_B), .SC(SH2_C), .MASK(MASK2)) u_step2 (
    .st  (st2),
    .nxt (nxt2)
  );

  // The seed-load edge only scrambles s into the state; y stays 0 until the next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st0    <= C0 | MIN_OR0;
      st1    <= C1 | MIN_OR1;
      st2    <= C2 | MIN_OR2;
      seeded <= 1'b0;
      y      <= '0;
    end else if (!seeded) begin
      st0    <= (s ^ C0) | MIN_OR0;
      st1    <= (s ^ C1) | MIN_OR1;
      st2    <= (s ^ C2) | MIN_OR2;
      seeded <= 1'b1;
    end else begin
      st0 <= nxt0;
      st1 <= nxt1;
      st2 <= nxt2;
      y   <= nxt0 ^ nxt1 ^ nxt2;
    end
  end

endmodule

// File: tb/tb_tausworthe.sv
// Scoreboard bench for tausworthe: the driver queues the expected y for each
// edge, an independent negedge monitor pops and compares against the DUT.
module tb_tausworthe;

  logic        clk;
  logic        reset;
  logic [31:0] s;
  logic [31:0] y;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  int          idx_q[$];
  int          push_idx = 0;

  logic [31:0] m0, m1, m2, my;

  localparam int NSTAT = 20000;

  tausworthe dut (
    .clk   (clk),
    .reset (reset),
    .s     (s),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  function automatic void chk_range(input string name, input real act, input real lo, input real hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s actual=%f required=[%f,%f]", name, act, lo, hi);
    end
  endfunction

  function automatic void push(input logic [31:0] v);
    exp_q.push_back(v);
    idx_q.push_back(push_idx);
    push_idx++;
  endfunction

  // Reference taus88 as written in the original C
  task automatic model_seed(input logic [31:0] seed);
    m0 = (seed ^ 32'h1234_5678) | 32'h2;
    m1 = (seed ^ 32'h8765_4321) | 32'h8;
    m2 = (seed ^ 32'hDEAD_BEEF) | 32'h10;
  endtask

  task automatic model_next();
    logic [31:0] b;
    b  = ((m0 << 13) ^ m0) >> 19;
    m0 = ((m0 & 32'hFFFF_FFFE) << 12) ^ b;
    b  = ((m1 << 2) ^ m1) >> 25;
    m1 = ((m1 & 32'hFFFF_FFF8) << 4) ^ b;
    b  = ((m2 << 3) ^ m2) >> 11;
    m2 = ((m2 & 32'hFFFF_FFF0) << 17) ^ b;
    my = m0 ^ m1 ^ m2;
  endtask

  initial begin : monitor
    logic [31:0] e;
    int          k;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        k = idx_q.pop_front();
        chk($sformatf("y[%0d]", k), y, e);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    real   sum;
    int    ones[32];
    int    minviol;

    reset = 1'b1;
    s     = 'x;
    repeat (3) begin
      @(posedge clk); #1;
      push(32'h0);
    end
    @(negedge clk);
    chk("y_known_in_reset", {31'b0, $isunknown(y)}, 32'h0);
    chk("rst_st0", dut.st0, 32'h1234_567A);
    chk("rst_st1", dut.st1, 32'h8765_4329);
    chk("rst_st2", dut.st2, 32'hDEAD_BEFF);

    reset = 1'b0;
    s     = 32'h0;
    @(posedge clk); #1;
    chk("seed_st0", dut.st0, 32'h1234_567A);
    chk("seed_st1", dut.st1, 32'h8765_4329);
    chk("seed_st2", dut.st2, 32'hDEAD_BEFF);
    push(32'h0);
    @(posedge clk); #1;
    chk("step1_st0", dut.st0, 32'h4567_B31F);
    chk("step1_st1", dut.st1, 32'h7654_32CD);
    chk("step1_st2", dut.st2, 32'h7DE5_7809);
    push(32'h4ED6_F9DB);

    m0 = 32'h4567_B31F;
    m1 = 32'h7654_32CD;
    m2 = 32'h7DE5_7809;
    repeat (1000) begin
      @(posedge clk); #1;
      model_next();
      push(my);
    end

    // asynchronous reset between edges must clear y without waiting for a clock
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("async_rst_y", y, 32'h0);
    chk("async_rst_seeded", {31'b0, dut.seeded}, 32'h0);
    chk("async_rst_st0", dut.st0, 32'h1234_567A);
    s = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    push(32'h0);
    s = $urandom;
    @(posedge clk); #1;
    push(32'h4ED6_F9DB);
    model_seed(32'h0);
    model_next();
    repeat (300) begin
      s = $urandom;
      @(posedge clk); #1;
      model_next();
      push(my);
    end

    @(negedge clk);
    reset = 1'b1;
    s     = 32'hFFFF_FFFF;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    push(32'h0);
    model_seed(32'hFFFF_FFFF);
    chk("ones_seed_st0", dut.st0, m0);
    chk("ones_seed_st1", dut.st1, m1);
    chk("ones_seed_st2", dut.st2, m2);

    sum     = 0.0;
    minviol = 0;
    for (int b = 0; b < 32; b++) ones[b] = 0;
    for (int n = 0; n < NSTAT; n++) begin
      @(posedge clk); #1;
      model_next();
      push(my);
      sum += real'(longint'(y));
      for (int b = 0; b < 32; b++) ones[b] += int'(y[b]);
      if (dut.st0 <= 32'd1 || dut.st1 <= 32'd7 || dut.st2 <= 32'd15) minviol++;
    end
    chk("state_min_violations", minviol, 32'h0);
    chk_range("mean", sum / (real'(NSTAT) * 4294967296.0), 0.49, 0.51);
    for (int b = 0; b < 32; b++)
      chk_range($sformatf("bit%0d_ones", b), real'(ones[b]) / real'(NSTAT), 0.48, 0.52);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
